// File: rtl/mem_seq_pkg.sv
// Shared types and default constants for the memory port sequencer.
// Types: state_e (IDLE/WAIT/RESP), region_e (ROM/RAM), port_e (IF/DM).
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        RGN_ROM,
        RGN_RAM
    } region_e;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_e;

    localparam logic [31:0] DEF_TEXT_BASE   = 32'h0040_0000;
    localparam logic [31:0] DEF_DATA_BASE   = 32'h1001_0000;
    localparam int          DEF_ROM_DEPTH   = 64;
    localparam int          DEF_RAM_DEPTH   = 64;
    localparam int          DEF_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational byte-address decode into region, word offset and error flag.
// Ports: addr_i/write_i in; region_o, word_o (32-bit word offset), err_o out.
// MEM_SEQ_ADDR_CHECK_EN enables alignment/mapping/store-to-ROM checks.
module mem_addr_decode
    import mem_seq_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE,
    parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
    parameter int          ROM_DEPTH = DEF_ROM_DEPTH,
    parameter int          RAM_DEPTH = DEF_RAM_DEPTH
) (
    input  logic [31:0] addr_i,
    input  logic        write_i,
    output region_e     region_o,
    output logic [31:0] word_o,
    output logic        err_o
);

    localparam logic [31:0] ROM_BYTES = 32'(4 * ROM_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_DEPTH);

    logic [31:0] text_off;
    logic [31:0] data_off;

    assign text_off = addr_i - TEXT_BASE;
    assign data_off = addr_i - DATA_BASE;

`ifdef MEM_SEQ_ADDR_CHECK_EN
    logic in_rom;
    logic in_ram;
    logic misal;

    assign in_rom   = (addr_i >= TEXT_BASE) && (text_off < ROM_BYTES);
    assign in_ram   = (addr_i >= DATA_BASE) && (data_off < RAM_BYTES);
    assign misal    = (addr_i[1:0] != 2'b00);
    assign region_o = in_ram ? RGN_RAM : RGN_ROM;
    assign err_o    = misal | ~(in_rom | in_ram) | (write_i & in_rom);
`else
    logic unused_dec;

    // Without checks the map is split at DATA_BASE only.
    assign unused_dec = write_i ^ (|ROM_BYTES) ^ (|RAM_BYTES);
    assign region_o   = (addr_i >= DATA_BASE) ? RGN_RAM : RGN_ROM;
    assign err_o      = 1'b0;
`endif

    assign word_o = ((region_o == RGN_RAM) ? data_off : text_off) >> 2;

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares ROM/RAM between the fetch and load/store ports with round-robin
// arbitration and a fixed-latency IDLE/WAIT/RESP sequence.
// Ports: If_* fetch port, Dm_* data port, Rom_*/Ram_* memory side,
// Busy_o, Addr_Err_o. MEM_SEQ_ADDR_CHECK_EN enables address checking.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE   = DEF_TEXT_BASE,
    parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
    parameter int          ROM_DEPTH   = DEF_ROM_DEPTH,
    parameter int          RAM_DEPTH   = DEF_RAM_DEPTH,
    parameter int          MEM_LATENCY = DEF_MEM_LATENCY,
    localparam int         IDX_R       = $clog2(ROM_DEPTH),
    localparam int         IDX_D       = $clog2(RAM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             If_Req_i,
    input  logic [31:0]      If_Address_i,
    output logic             If_Done_o,
    output logic [31:0]      If_Instruction_o,
    input  logic             Dm_Req_i,
    input  logic             Dm_Write_i,
    input  logic [31:0]      Dm_Address_i,
    input  logic [31:0]      Dm_WriteData_i,
    output logic             Dm_Done_o,
    output logic [31:0]      Dm_ReadData_o,
    output logic [IDX_R-1:0] Rom_Index_o,
    input  logic [31:0]      Rom_Data_i,
    output logic [IDX_D-1:0] Ram_Index_o,
    output logic             Ram_WriteEnable_o,
    output logic [31:0]      Ram_WriteData_o,
    input  logic [31:0]      Ram_Data_i,
    output logic             Busy_o,
    output logic             Addr_Err_o
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_CNT = CW'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    port_e             port_q, last_q;
    region_e           region_q;
    logic              write_q, err_q, we_q;
    logic [CW-1:0]     cnt_q;
    logic [IDX_R-1:0]  rom_idx_q;
    logic [IDX_D-1:0]  ram_idx_q;
    logic [31:0]       wdata_q, inst_q, rdata_q;

    logic              req_any, pick_dm, gnt_write;
    port_e             gnt_port;
    logic [31:0]       gnt_addr, dec_word, rd_mux;
    region_e           dec_region;
    logic              dec_err, unused_word;

    // DM wins a tie only when IF was the last port served.
    assign req_any   = If_Req_i | Dm_Req_i;
    assign pick_dm   = Dm_Req_i & (~If_Req_i | (last_q == PORT_IF));
    assign gnt_port  = pick_dm ? PORT_DM : PORT_IF;
    assign gnt_addr  = pick_dm ? Dm_Address_i : If_Address_i;
    assign gnt_write = pick_dm & Dm_Write_i;

    mem_addr_decode #(
        .TEXT_BASE (TEXT_BASE),
        .DATA_BASE (DATA_BASE),
        .ROM_DEPTH (ROM_DEPTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_dec (
        .addr_i   (gnt_addr),
        .write_i  (gnt_write),
        .region_o (dec_region),
        .word_o   (dec_word),
        .err_o    (dec_err)
    );

    assign unused_word = ^dec_word;
    assign rd_mux = (region_q == RGN_RAM) ? Ram_Data_i : Rom_Data_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_any) state_d = dec_err ? RESP : WAIT;
            WAIT: if (cnt_q == '0) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        If_Done_o  = 1'b0;
        Dm_Done_o  = 1'b0;
        Addr_Err_o = 1'b0;
        Busy_o     = (state_q != IDLE);
        if (state_q == RESP) begin
            If_Done_o  = (port_q == PORT_IF);
            Dm_Done_o  = (port_q == PORT_DM);
            Addr_Err_o = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_q    <= PORT_IF;
            last_q    <= PORT_DM;
            region_q  <= RGN_ROM;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            rom_idx_q <= '0;
            ram_idx_q <= '0;
            wdata_q   <= '0;
            inst_q    <= '0;
            rdata_q   <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        port_q   <= gnt_port;
                        last_q   <= gnt_port;
                        write_q  <= gnt_write;
                        err_q    <= dec_err;
                        region_q <= dec_region;
                        cnt_q    <= LOAD_CNT;
                        if (gnt_write) wdata_q <= Dm_WriteData_i;
                        if (!dec_err) begin
                            // Stores always target RAM, even from ROM space.
                            if (gnt_write) begin
                                ram_idx_q <= dec_word[IDX_D-1:0];
                                we_q      <= 1'b1;
                            end else if (dec_region == RGN_RAM) begin
                                ram_idx_q <= dec_word[IDX_D-1:0];
                            end else begin
                                rom_idx_q <= dec_word[IDX_R-1:0];
                            end
                        end else if (gnt_port == PORT_IF) begin
                            inst_q <= '0;
                        end else if (!gnt_write) begin
                            rdata_q <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (!write_q) begin
                            if (port_q == PORT_IF) inst_q <= rd_mux;
                            else rdata_q <= rd_mux;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign If_Instruction_o  = inst_q;
    assign Dm_ReadData_o     = rdata_q;
    assign Rom_Index_o       = rom_idx_q;
    assign Ram_Index_o       = ram_idx_q;
    assign Ram_WriteEnable_o = we_q;
    assign Ram_WriteData_o   = wdata_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench for mem_port_sequencer: vector table, directed
// corner sequences and a randomized two-requester run against a memory model.
module tb_mem_port_sequencer;

    localparam int LAT   = 2;
    localparam int BOUND = 3 * (LAT + 2);
    localparam logic [31:0] TB_TEXT = 32'h0040_0000;
    localparam logic [31:0] TB_DATA = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        If_Req_i = 1'b0;
    logic [31:0] If_Address_i = '0;
    logic        If_Done_o;
    logic [31:0] If_Instruction_o;
    logic        Dm_Req_i = 1'b0;
    logic        Dm_Write_i = 1'b0;
    logic [31:0] Dm_Address_i = '0;
    logic [31:0] Dm_WriteData_i = '0;
    logic        Dm_Done_o;
    logic [31:0] Dm_ReadData_o;
    logic [5:0]  Rom_Index_o;
    logic [31:0] Rom_Data_i;
    logic [5:0]  Ram_Index_o;
    logic        Ram_WriteEnable_o;
    logic [31:0] Ram_WriteData_o;
    logic [31:0] Ram_Data_i;
    logic        Busy_o;
    logic        Addr_Err_o;

    mem_port_sequencer #(.MEM_LATENCY(LAT)) dut (
        .clk               (clk),
        .reset             (reset),
        .If_Req_i          (If_Req_i),
        .If_Address_i      (If_Address_i),
        .If_Done_o         (If_Done_o),
        .If_Instruction_o  (If_Instruction_o),
        .Dm_Req_i          (Dm_Req_i),
        .Dm_Write_i        (Dm_Write_i),
        .Dm_Address_i      (Dm_Address_i),
        .Dm_WriteData_i    (Dm_WriteData_i),
        .Dm_Done_o         (Dm_Done_o),
        .Dm_ReadData_o     (Dm_ReadData_o),
        .Rom_Index_o       (Rom_Index_o),
        .Rom_Data_i        (Rom_Data_i),
        .Ram_Index_o       (Ram_Index_o),
        .Ram_WriteEnable_o (Ram_WriteEnable_o),
        .Ram_WriteData_o   (Ram_WriteData_o),
        .Ram_Data_i        (Ram_Data_i),
        .Busy_o            (Busy_o),
        .Addr_Err_o        (Addr_Err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(int i);
        return (i == 2) ? 32'h2008_000A : (32'hC0DE_0000 | 32'(i * 7));
    endfunction

    function automatic logic [31:0] ram_init(int i);
        return 32'h5A00_0000 + 32'(i * 13);
    endfunction

    // Memory arrays behind the DUT.
    logic [31:0] rom_mem [64];
    logic [31:0] ram_mem [64];
    logic [31:0] ref_ram [64];

    assign Rom_Data_i = rom_mem[Rom_Index_o];
    assign Ram_Data_i = ram_mem[Ram_Index_o];

    always @(posedge clk)
        if (Ram_WriteEnable_o) ram_mem[Ram_Index_o] <= Ram_WriteData_o;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        If_Req_i = 1'b0;
        Dm_Req_i = 1'b0;
        Dm_Write_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Results captured by run_txn.
    int          t_lat, t_we;
    logic [31:0] t_rd;
    logic        t_err, t_busy1;
    logic [5:0]  t_ridx, t_didx;

    // Called at a negedge of an IDLE cycle: that cycle is cycle 0.
    task automatic run_txn(input bit p_if, input bit wr,
                           input logic [31:0] a, input logic [31:0] wd);
        t_lat = -1;
        t_we = 0;
        t_rd = '0;
        t_err = 1'b0;
        if (p_if) begin
            If_Req_i = 1'b1;
            If_Address_i = a;
        end else begin
            Dm_Req_i = 1'b1;
            Dm_Write_i = wr;
            Dm_Address_i = a;
            Dm_WriteData_i = wd;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (Ram_WriteEnable_o) t_we++;
            if (c == 1) begin
                t_ridx = Rom_Index_o;
                t_didx = Ram_Index_o;
                t_busy1 = Busy_o;
            end
            if (p_if ? If_Done_o : Dm_Done_o) begin
                t_lat = c;
                t_rd = p_if ? If_Instruction_o : Dm_ReadData_o;
                t_err = Addr_Err_o;
                break;
            end
        end
        If_Req_i = 1'b0;
        Dm_Req_i = 1'b0;
        Dm_Write_i = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit          p_if;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          ram_side;
        int          exp_idx;
        logic [31:0] exp_rd;
        int          exp_we;
    } vec_t;

    vec_t vt [8];

    bit          if_pend, dm_pend, dm_wr, dm_txt;
    int          if_age, dm_age, if_idx, dm_idx;
    logic [31:0] dm_wd, exp_w;

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_mem[i] = rom_word(i);
            ram_mem[i] = ram_init(i);
            ref_ram[i] = ram_init(i);
        end

        vt[0] = '{1, 0, 32'h0040_0008, 0, 0, 2, 32'h2008_000A, 0};
        vt[1] = '{0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 1, 1, 0, 1};
        vt[2] = '{0, 0, 32'h1001_0004, 0, 1, 1, 32'hDEAD_BEEF, 0};
        vt[3] = '{0, 0, 32'h0040_0010, 0, 0, 4, rom_word(4), 0};
        vt[4] = '{1, 0, 32'h0040_00FC, 0, 0, 63, rom_word(63), 0};
        vt[5] = '{0, 1, 32'h1001_00FC, 32'h1234_5678, 1, 63, 0, 1};
        vt[6] = '{0, 0, 32'h1001_00FC, 0, 1, 63, 32'h1234_5678, 0};
        vt[7] = '{0, 0, 32'h1001_0000, 0, 1, 0, ram_init(0), 0};

        do_reset();
        chk1("rst_busy", Busy_o, 1'b0);
        chk1("rst_if_done", If_Done_o, 1'b0);
        chk1("rst_dm_done", Dm_Done_o, 1'b0);
        chk1("rst_we", Ram_WriteEnable_o, 1'b0);
        chk1("rst_err", Addr_Err_o, 1'b0);
        chk32("rst_inst", If_Instruction_o, '0);
        chk32("rst_rdata", Dm_ReadData_o, '0);
        chk32("rst_rom_idx", 32'(Rom_Index_o), '0);
        chk32("rst_ram_idx", 32'(Ram_Index_o), '0);
        chk32("rst_wdata", Ram_WriteData_o, '0);

        for (int v = 0; v < 8; v++) begin
            run_txn(vt[v].p_if, vt[v].wr, vt[v].addr, vt[v].wd);
            chk32("vec_latency", 32'(t_lat), 32'(LAT + 1));
            chk1("vec_busy_c1", t_busy1, 1'b1);
            chk1("vec_err", t_err, 1'b0);
            chk32("vec_we_cycles", 32'(t_we), 32'(vt[v].exp_we));
            chk32("vec_index", 32'(vt[v].ram_side ? t_didx : t_ridx),
                  32'(vt[v].exp_idx));
            if (!vt[v].wr) chk32("vec_rdata", t_rd, vt[v].exp_rd);
            else ref_ram[vt[v].exp_idx] = vt[v].wd;
        end

        // Both ports held from reset: IF first, then strict alternation.
        do_reset();
        If_Req_i = 1'b1;
        If_Address_i = 32'h0040_0000;
        Dm_Req_i = 1'b1;
        Dm_Write_i = 1'b0;
        Dm_Address_i = 32'h1001_0010;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk1("alt_if_done", If_Done_o, (c % 8) == 3);
            chk1("alt_dm_done", Dm_Done_o, (c % 8) == 7);
            chk1("alt_busy", Busy_o, (c % 4) != 0);
            if ((c % 8) == 3) chk32("alt_inst", If_Instruction_o, rom_word(0));
            if ((c % 8) == 7) chk32("alt_rdata", Dm_ReadData_o, ref_ram[4]);
        end
        If_Req_i = 1'b0;
        Dm_Req_i = 1'b0;
        @(negedge clk);

        // Reset during the write-strobe cycle of a store.
        Dm_Req_i = 1'b1;
        Dm_Write_i = 1'b1;
        Dm_Address_i = 32'h1001_0008;
        Dm_WriteData_i = 32'h55AA_55AA;
        @(negedge clk);
        chk1("abort_we_before", Ram_WriteEnable_o, 1'b1);
        reset = 1'b0;
        Dm_Req_i = 1'b0;
        Dm_Write_i = 1'b0;
        #1;
        chk1("abort_we_now", Ram_WriteEnable_o, 1'b0);
        chk1("abort_busy_now", Busy_o, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1("abort_no_done", Dm_Done_o, 1'b0);
            chk1("abort_idle", Busy_o, 1'b0);
        end
        run_txn(0, 0, 32'h1001_0008, 0);
        chk32("abort_not_written", t_rd, ref_ram[2]);
        chk32("abort_next_lat", 32'(t_lat), 32'(LAT + 1));

`ifdef MEM_SEQ_ADDR_CHECK_EN
        run_txn(0, 0, 32'h1001_0002, 0);
        chk32("misal_lat", 32'(t_lat), 32'd1);
        chk1("misal_err", t_err, 1'b1);
        chk32("misal_rdata", t_rd, '0);
        chk32("misal_we", 32'(t_we), '0);
        run_txn(0, 1, 32'h0040_0000, 32'hFFFF_FFFF);
        chk32("romst_lat", 32'(t_lat), 32'd1);
        chk1("romst_err", t_err, 1'b1);
        chk32("romst_we", 32'(t_we), '0);
`else
        run_txn(0, 1, 32'h0040_0000, 32'hFFFF_0001);
        chk32("romst_lat", 32'(t_lat), 32'(LAT + 1));
        chk1("romst_err", t_err, 1'b0);
        chk32("romst_we", 32'(t_we), 32'd1);
        chk32("romst_idx", 32'(t_didx), '0);
        ref_ram[0] = 32'hFFFF_0001;
        run_txn(0, 0, 32'h1001_0000, 0);
        chk32("romst_readback", t_rd, ref_ram[0]);
`endif

        // Random traffic from two independent requesters.
        if_pend = 0;
        dm_pend = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (If_Done_o && Dm_Done_o) chk1("rnd_dual_done", 1'b1, 1'b0);
            if (If_Done_o) begin
                if (!if_pend) chk1("rnd_if_spurious", 1'b1, 1'b0);
                else chk32("rnd_if_data", If_Instruction_o, rom_word(if_idx));
                if_pend = 0;
            end
            if (Dm_Done_o) begin
                if (!dm_pend) begin
                    chk1("rnd_dm_spurious", 1'b1, 1'b0);
                end else if (dm_wr) begin
                    ref_ram[dm_idx] = dm_wd;
                    chk1("rnd_dm_err", Addr_Err_o, 1'b0);
                end else begin
                    exp_w = dm_txt ? rom_word(dm_idx) : ref_ram[dm_idx];
                    chk32("rnd_dm_data", Dm_ReadData_o, exp_w);
                end
                dm_pend = 0;
            end
            if (if_pend && ++if_age > BOUND) begin
                chk1("rnd_if_timeout", 1'b1, 1'b0);
                if_pend = 0;
            end
            if (dm_pend && ++dm_age > BOUND) begin
                chk1("rnd_dm_timeout", 1'b1, 1'b0);
                dm_pend = 0;
            end
            if (!if_pend) begin
                If_Req_i = 1'b0;
                if (cyc < 1980 && $urandom_range(0, 1) == 1) begin
                    if_pend = 1;
                    if_age = 0;
                    if_idx = int'($urandom_range(0, 63));
                    If_Req_i = 1'b1;
                    If_Address_i = TB_TEXT + 32'(if_idx * 4);
                end
            end
            if (!dm_pend) begin
                Dm_Req_i = 1'b0;
                Dm_Write_i = 1'b0;
                if (cyc < 1980 && $urandom_range(0, 1) == 1) begin
                    dm_pend = 1;
                    dm_age = 0;
                    dm_idx = int'($urandom_range(0, 63));
                    dm_txt = ($urandom_range(0, 3) == 0);
                    dm_wr = !dm_txt && ($urandom_range(0, 2) == 0);
                    dm_wd = $urandom;
                    Dm_Req_i = 1'b1;
                    Dm_Write_i = dm_wr;
                    Dm_WriteData_i = dm_wd;
                    Dm_Address_i = (dm_txt ? TB_TEXT : TB_DATA) + 32'(dm_idx * 4);
                end
            end
        end
        chk1("rnd_drained", if_pend | dm_pend, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
